// File: rtl/fpcmp_arb_pkg.sv
// rtl/fpcmp_arb_pkg.sv - shared types and widths for the fpcmp arbiter
package fpcmp_arb_pkg;

  localparam int FLAG_W = 5;
  localparam int PRED_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fpcmp_arb_if.sv
// rtl/fpcmp_arb_if.sv - requester and fpcmp-side signal bundle of the arbiter
interface fpcmp_arb_if
  import fpcmp_arb_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]        req;
  logic [PRED_W*NREQ-1:0] req_pred;
  logic [32*NREQ-1:0]     req_x;
  logic [32*NREQ-1:0]     req_y;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic                   res_z;
  logic [FLAG_W-1:0]      res_flags;
  logic                   fp_run;
  logic                   fp_stall;
  logic [PRED_W-1:0]      fp_pred;
  logic [31:0]            fp_x;
  logic [31:0]            fp_y;
  logic                   fp_z;
  logic [FLAG_W-1:0]      fp_flags;

  modport master (
    input  req, req_pred, req_x, req_y, fp_stall, fp_z, fp_flags,
    output gnt, done, res_z, res_flags, fp_run, fp_pred, fp_x, fp_y
  );

  modport slave (
    output req, req_pred, req_x, req_y, fp_stall, fp_z, fp_flags,
    input  gnt, done, res_z, res_flags, fp_run, fp_pred, fp_x, fp_y
  );

endinterface

// File: rtl/fpcmp_rr_pick.sv
// rtl/fpcmp_rr_pick.sv - combinational round-robin picker starting at ptr
module fpcmp_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx,
  output logic [NREQ-1:0] onehot
);

  logic [NREQ-1:0] rot;
  logic [IW:0]     off;
  logic [IW:0]     sum;

  // Rotating the doubled vector puts requester ptr at bit 0, so the lowest set bit wins.
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    any = |req;
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = (IW+1)'(i);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
    idx = sum[IW-1:0];
    onehot = '0;
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/fpcmp_arb.sv
// rtl/fpcmp_arb.sv - round-robin sharing of one fpcmp unit between NREQ requesters
module fpcmp_arb
  import fpcmp_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic         clk,
  input logic         rst,
  fpcmp_arb_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     win;
  logic              pick_any;
  logic [IW-1:0]     pick_idx;
  logic [NREQ-1:0]   pick_onehot;
  logic [PRED_W-1:0] sel_pred;
  logic [31:0]       sel_x;
  logic [31:0]       sel_y;

  fpcmp_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    sel_pred = '0;
    sel_x    = '0;
    sel_y    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_onehot[i]) begin
        sel_pred = bus.req_pred[i*PRED_W +: PRED_W];
        sel_x    = bus.req_x[i*32 +: 32];
        sel_y    = bus.req_y[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      win           <= '0;
      bus.gnt       <= '0;
      bus.done      <= '0;
      bus.fp_run    <= 1'b0;
      bus.res_z     <= 1'b0;
      bus.res_flags <= '0;
      bus.fp_pred   <= '0;
      bus.fp_x      <= '0;
      bus.fp_y      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            win         <= pick_idx;
            bus.gnt     <= pick_onehot;
            bus.fp_pred <= sel_pred;
            bus.fp_x    <= sel_x;
            bus.fp_y    <= sel_y;
            bus.fp_run  <= 1'b1;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!bus.fp_stall) begin
            bus.res_z     <= bus.fp_z;
            bus.res_flags <= bus.fp_flags;
            bus.done      <= bus.gnt;
            bus.fp_run    <= 1'b0;
            ptr           <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          // req is deliberately ignored here; a held request is seen again in IDLE.
          bus.done <= '0;
          bus.gnt  <= '0;
          state    <= ST_IDLE;
        end
        default: begin
          bus.done   <= '0;
          bus.gnt    <= '0;
          bus.fp_run <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpcmp_arb.sv
// tb/tb_fpcmp_arb.sv - self-checking bench for fpcmp_arb with a stand-in fpcmp model
module tb_fpcmp_arb;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   model_ptr = 0;

  logic [2:0]  op_p [NREQ];
  logic [31:0] op_x [NREQ];
  logic [31:0] op_y [NREQ];
  logic [5:0]  fpc_out;

  fpcmp_arb_if #(.NREQ(NREQ)) bus ();

  fpcmp_arb #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the fpcmp unit: returns {z, flags}.
  function automatic logic [5:0] fpc_model(input logic [2:0] p, input logic [31:0] a, input logic [31:0] b);
    logic an, bn, un, eq, lt, z;
    logic [4:0] f;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    un = an | bn;
    eq = !un && ((a == b) || (a[30:0] == 0 && b[30:0] == 0));
    if (un)                lt = 1'b0;
    else if (a[31] != b[31]) lt = a[31] && !eq;
    else if (a[31])        lt = a[30:0] > b[30:0];
    else                   lt = a[30:0] < b[30:0];
    case (p)
      3'd0:    z = eq;
      3'd1:    z = lt;
      3'd2:    z = lt | eq;
      3'd3:    z = un;
      3'd4:    z = !eq;
      default: z = !(lt | eq) && !un;
    endcase
    f = {un && (p == 3'd1 || p == 3'd2), 3'b000, (an && !a[22]) || (bn && !b[22])};
    return {z, f};
  endfunction

  assign fpc_out       = fpc_model(bus.fp_pred, bus.fp_x, bus.fp_y);
  assign bus.fp_z      = fpc_out[5];
  assign bus.fp_flags  = fpc_out[4:0];

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] v;
    v = '0;
    if (w >= 0 && w < NREQ) v[w] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rnd_fp();
    case ($urandom_range(0, 5))
      0:       return 32'h7FC00000;
      1:       return 32'h00000000;
      2:       return 32'h80000000;
      3:       return 32'h3F800000;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [2:0] p, input logic [31:0] x, input logic [31:0] y);
    op_p[i] = p;
    op_x[i] = x;
    op_y[i] = y;
    bus.req_pred[i*3 +: 3] = p;
    bus.req_x[i*32 +: 32]  = x;
    bus.req_y[i*32 +: 32]  = y;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // One complete operation from an IDLE cycle, predicted from the round-robin rule.
  task automatic serve(input logic [NREQ-1:0] mask, input int s, input bit keep, output int w);
    logic [5:0]  e;
    logic [31:0] lx;
    int c;
    w  = rr_pick(mask, model_ptr);
    e  = fpc_model(op_p[w], op_x[w], op_y[w]);
    lx = op_x[w];
    bus.req = mask;
    bus.fp_stall = (s > 0);
    step();
    chk("grant_gnt", bus.gnt, onehot(w));
    chk("grant_run", bus.fp_run, 1);
    chk("grant_fp_x", bus.fp_x, lx);
    if (!keep) begin
      bus.req = '0;
      for (int i = 0; i < NREQ; i++) set_op(i, 3'($urandom), rnd_fp(), rnd_fp());
    end
    c = 1;
    while (c < 40) begin
      step();
      c++;
      if (bus.done != 0) break;
      chk("run_hold_x", bus.fp_x, lx);
      chk("run_level", bus.fp_run, 1);
      bus.fp_stall = (c <= s);
    end
    bus.fp_stall = 1'b0;
    chk("latency", c, s + 2);
    chk("done_bits", bus.done, onehot(w));
    chk("res_z", bus.res_z, e[5]);
    chk("res_flags", bus.res_flags, e[4:0]);
    chk("done_run", bus.fp_run, 0);
    model_ptr = (w + 1) % NREQ;
    step();
    chk("idle_gnt", bus.gnt, 0);
    chk("idle_done", bus.done, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("done_onehot", $onehot0(bus.done), 1);
      chk("gnt_onehot", $onehot0(bus.gnt), 1);
      chk("done_in_gnt", bus.done & ~bus.gnt, 0);
    end
  end

  initial begin
    int w;
    int n;
    int seen_idx [5];
    int seen_cyc [5];
    logic [5:0] e;

    bus.req = '0;
    bus.req_pred = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.fp_stall = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 3'd0, 32'h0, 32'h0);

    // reset values
    rst = 1'b1;
    step();
    step();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_run", bus.fp_run, 0);
    chk("rst_res_z", bus.res_z, 0);
    chk("rst_res_flags", bus.res_flags, 0);
    chk("rst_fp_pred", bus.fp_pred, 0);
    chk("rst_fp_x", bus.fp_x, 0);
    chk("rst_fp_y", bus.fp_y, 0);
    rst = 1'b0;
    model_ptr = 0;

    // single requester 2, no stall
    set_op(2, 3'b001, 32'h3F800000, 32'h40000000);
    e = fpc_model(3'b001, 32'h3F800000, 32'h40000000);
    bus.req = 4'b0100;
    step();
    chk("t1_gnt", bus.gnt, 4'b0100);
    chk("t1_run", bus.fp_run, 1);
    chk("t1_fp_x", bus.fp_x, 32'h3F800000);
    chk("t1_fp_pred", bus.fp_pred, 3'b001);
    chk("t1_no_done", bus.done, 0);
    bus.req = '0;
    step();
    chk("t1_done", bus.done, 4'b0100);
    chk("t1_run_off", bus.fp_run, 0);
    chk("t1_res_z", bus.res_z, e[5]);
    chk("t1_res_z_val", bus.res_z, 1);
    chk("t1_res_flags", bus.res_flags, e[4:0]);
    step();
    chk("t1_idle_done", bus.done, 0);
    chk("t1_idle_gnt", bus.gnt, 0);
    model_ptr = 3;

    // requester 0 with three stall cycles
    set_op(0, 3'b010, 32'hC0400000, 32'h3F800000);
    e = fpc_model(3'b010, 32'hC0400000, 32'h3F800000);
    bus.fp_stall = 1'b1;
    bus.req = 4'b0001;
    step();
    chk("t2_gnt", bus.gnt, 4'b0001);
    chk("t2_run1", bus.fp_run, 1);
    bus.req = '0;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("t2_run", bus.fp_run, 1);
      chk("t2_fp_x_hold", bus.fp_x, 32'hC0400000);
      chk("t2_no_done", bus.done, 0);
      if (k == 4) bus.fp_stall = 1'b0;
    end
    step();
    chk("t2_done", bus.done, 4'b0001);
    chk("t2_run_off", bus.fp_run, 0);
    chk("t2_res_z", bus.res_z, e[5]);
    step();
    model_ptr = 1;

    // all four requesting continuously from reset
    for (int i = 0; i < NREQ; i++) set_op(i, 3'(i), rnd_fp(), rnd_fp());
    bus.req = 4'b1111;
    do_reset();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      seen_idx[i] = -1;
      seen_cyc[i] = -100;
    end
    for (int c = 0; c < 40 && n < 5; c++) begin
      step();
      if (bus.done != 0) begin
        seen_idx[n] = idx_of(bus.done);
        seen_cyc[n] = c;
        n++;
      end
    end
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_order", seen_idx[i], rr_pick(4'b1111, model_ptr));
      model_ptr = (rr_pick(4'b1111, model_ptr) + 1) % NREQ;
      if (i > 0) chk("t3_spacing", seen_cyc[i] - seen_cyc[i-1], 3);
    end

    // ptr=2 after serving 0 and 1, then 1010 serves 3 first
    do_reset();
    serve(4'b0001, 0, 1'b0, w);
    serve(4'b0010, 0, 1'b0, w);
    for (int i = 0; i < NREQ; i++) set_op(i, 3'($urandom), rnd_fp(), rnd_fp());
    serve(4'b1010, 0, 1'b1, w);
    serve(4'b1010, 1, 1'b0, w);

    // reset while stalled in RUN
    bus.fp_stall = 1'b1;
    bus.req = 4'b0100;
    step();
    chk("t5_run", bus.fp_run, 1);
    rst = 1'b1;
    bus.req = '0;
    step();
    chk("t5_rst_run", bus.fp_run, 0);
    chk("t5_rst_gnt", bus.gnt, 0);
    chk("t5_rst_done", bus.done, 0);
    rst = 1'b0;
    bus.fp_stall = 1'b0;
    model_ptr = 0;
    step();
    chk("t5_no_done", bus.done, 0);
    chk("t5_no_run", bus.fp_run, 0);
    serve(4'b1110, 0, 1'b0, w);

    // requester 1 drops req and changes x after grant
    set_op(1, 3'b001, 32'h3F000000, 32'h3F800000);
    serve(4'b0010, 1, 1'b0, w);

    // randomized operations
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, 3'($urandom), rnd_fp(), rnd_fp());
      serve(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), w);
    end
    bus.req = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpcmp_arb.md
Name: fpcmp_arb

Overview:
- Shares one fpcmp comparison unit between NREQ independent requesters using round-robin arbitration.
- Latches the winning requester's predicate and operands, then drives the fpcmp run/stall handshake.
- Returns z and flags to the winner with a one-cycle done pulse.
- Sits between the fpcmp instance and client blocks, such as a serial test controller and a future CPU FPU port.

Parameters:
- NREQ, 4, number of requesters (2..8); the index width is clog2(NREQ).

Ports:
- clk  in  1  system clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; bit i requests a compare
- req_pred  in  3*NREQ  predicate of requester i in bits [3i+2:3i]
- req_x  in  32*NREQ  operand x of requester i in bits [32i+31:32i]
- req_y  in  32*NREQ  operand y of requester i in bits [32i+31:32i]
- gnt  out  NREQ  one-hot; the requester currently being served
- done  out  NREQ  one-hot, one-cycle pulse; the served requester's result is valid
- res_z  out  1  comparison result of the last completed operation
- res_flags  out  5  exception flags of the last completed operation
- fp_run  out  1  to fpcmp run
- fp_stall  in  1  from fpcmp stall
- fp_pred  out  3  to fpcmp pred
- fp_x  out  32  to fpcmp x
- fp_y  out  32  to fpcmp y
- fp_z  in  1  from fpcmp z
- fp_flags  in  5  from fpcmp flags

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) forces:
  - state IDLE, priority pointer ptr=0
  - gnt=0, done=0, fp_run=0
  - res_z=0, res_flags=0
  - fp_pred/fp_x/fp_y=0
- Reset mid-operation abandons the operation: no done pulse; fp_run is 0 from the first cycle after the reset edge.
- State IDLE:
  - fp_run=0, gnt=0.
  - If req!=0, the winner is the first set bit searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1 (modulo wrap).
  - On that edge, register the winner index, gnt=onehot(winner), and the winner's pred/x/y into fp_pred/fp_x/fp_y. Next state RUN.
  - If req==0, stay in IDLE.
- State RUN:
  - fp_run=1; operand registers are held constant.
  - If fp_stall=1, stay in RUN.
  - If fp_stall=0, capture fp_z→res_z and fp_flags→res_flags, set done=onehot(winner), and set ptr=winner+1 (wrapping NREQ-1→0). Next state DONE.
- State DONE (exactly one cycle):
  - done asserted, gnt still asserted, fp_run=0. Next state IDLE.
  - req is not sampled in DONE; a requester that keeps req high issues a new request, evaluated in the following IDLE cycle.
- Latency with no stall: req rises at edge t (sampled in IDLE) → RUN during cycle t+1 → done high during cycle t+2. Each stall cycle adds one cycle.
- Throughput: one operation per 3 cycles minimum.
- res_z and res_flags hold their value until the next completion.
- Requester contract:
  - Hold req and operands stable until the request is granted; operands are latched at the grant edge and may change afterwards.
  - Dropping req after the grant does not cancel the operation; done still pulses.
- Simultaneous requests are resolved purely by ptr; there is no fixed priority beyond reset (ptr=0).
- Requesters never see fp_stall directly.
- At most one bit of gnt and of done is set at any time; done is a subset of gnt.

Decomposition:
- Shared package fpcmp_arb_pkg holds:
  - state encoding constants IDLE/RUN/DONE (2 bits)
  - flag-width constant 5
  - predicate-width constant 3
- Sub-module fpcmp_rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: any, idx, onehot.
  - Implementation: double-width rotate plus priority encoder.
- The top holds the FSM, the operand/result registers and the ptr update.

Test Plan:
- Single requester 2, pred=3'b001, x=32'h3F800000, y=32'h40000000, fp_stall=0 → fp_run high exactly 1 cycle with fp_x=3F800000; done=4'b0100 two cycles after the req edge; res_z and res_flags equal the fpcmp model's output.
- Requester 0 with fp_stall held high 3 cycles → fp_run high 4 cycles with operands constant; done=4'b0001 one cycle after stall drops; no other done bit ever set.
- req=4'b1111 held continuously from reset → done order 0,1,2,3,0 with a 3-cycle spacing between pulses.
- After serving 0 and 1 (ptr=2), assert req=4'b1010 → requester 3 served before requester 1.
- rst pulsed while in RUN with fp_stall=1 → fp_run=0 and gnt=0 the next cycle; no done pulse; the following request from requester 1 wins first from ptr=0.
- Requester 1 drops req and changes x right after the grant → the operation completes with the latched x; done=4'b0010 still pulses.
